// File: rtl/tcpc_pkg.sv
// Shared encodings and constants for the TCPC receive path (state codes, SOP types, CRC-32 constants,
// receive-buffer register offsets).
package tcpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RECEIVE  = 3'd1,
        ST_CHECK    = 3'd2,
        ST_WR_TYPE  = 3'd3,
        ST_WR_COUNT = 3'd4,
        ST_DISCARD  = 3'd5
    } rx_state_t;

    localparam logic [2:0] SOP_TYPE_SOP    = 3'd0;
    localparam logic [2:0] SOP_TYPE_P      = 3'd1;
    localparam logic [2:0] SOP_TYPE_PP     = 3'd2;
    localparam logic [2:0] SOP_TYPE_DBG_P  = 3'd3;
    localparam logic [2:0] SOP_TYPE_DBG_PP = 3'd4;

    // CRC register is kept in the non-reflected orientation; bytes are fed LSB first.
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;

    localparam logic [7:0] RX_BASE_DFLT   = 8'h30;
    localparam logic [7:0] OFS_BYTE_COUNT = 8'd0;
    localparam logic [7:0] OFS_FRAME_TYPE = 8'd1;
    localparam logic [7:0] OFS_DATA       = 8'd2;

    localparam int MIN_BYTES = 6;
    localparam int CRC_BYTES = 4;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } bus_wr_t;

endpackage

// File: rtl/rx_phy_framer_if.sv
// Decoded-symbol stream from the BMC/4b5b PHY decoder: master is the decoder, slave is the framer.
interface rx_phy_framer_if;

    logic       phy_sop_valid;
    logic [2:0] phy_sop_type;
    logic       phy_byte_valid;
    logic [7:0] phy_byte;
    logic       phy_eop;
    logic       phy_error;

    modport master (
        output phy_sop_valid,
        output phy_sop_type,
        output phy_byte_valid,
        output phy_byte,
        output phy_eop,
        output phy_error
    );

    modport slave (
        input phy_sop_valid,
        input phy_sop_type,
        input phy_byte_valid,
        input phy_byte,
        input phy_eop,
        input phy_error
    );

endinterface

// File: rtl/rx_phy_framer_crc32_byte.sv
// crc32_byte: combinational one-byte CRC-32 update, byte consumed LSB first, 8 unrolled bit steps.
module crc32_byte
    import tcpc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] w_c;

    always_comb begin
        w_c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (w_c[31] ^ data_in[i]) begin
                w_c = {w_c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_c = {w_c[30:0], 1'b0};
            end
        end
        crc_out = w_c;
    end

endmodule

// File: rtl/rx_phy_framer.sv
// rx_phy_framer: SOP filter, CRC-stripping byte writer and CRC-32 checker feeding the TCPCI receive buffer.
// Optional build macro RX_CRC_ERR_CNT_EN adds the saturating crc_err_count output.
module rx_phy_framer
    import tcpc_pkg::*;
#(
    parameter int         MAX_BYTES = 34,
    parameter logic [7:0] RX_BASE   = RX_BASE_DFLT
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cable_reset,
    rx_phy_framer_if.slave phy,
    input  logic [7:0]     RECEIVE_DETECT_IN,
    input  logic           rx_buffer_full,
    output logic           memory_request,
    output logic           RNW,
    output logic [7:0]     DirBus,
    output logic [7:0]     DataBusOut,
    output logic           rx_goodcrc,
    output logic [2:0]     rx_frame_type,
    output logic           idle
`ifdef RX_CRC_ERR_CNT_EN
    ,
    output logic [7:0]     crc_err_count
`endif
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    rx_state_t        r_state, w_nxt_state;
    logic [2:0]       r_type, w_nxt_type;
    logic [CNT_W-1:0] r_count, w_nxt_count;
    logic [31:0]      r_crc, w_nxt_crc, w_crc_upd;
    logic [3:0][7:0]  r_dly, w_nxt_dly;
    logic             r_mreq, w_nxt_mreq;
    bus_wr_t          r_wr, w_nxt_wr;
    logic             r_goodcrc, w_nxt_goodcrc;
    logic [2:0]       r_ftype, w_nxt_ftype;

    logic w_rst;
    logic w_sop_ok;
    logic w_crc_good;

    assign w_rst      = !reset_n || cable_reset;
    assign w_sop_ok   = RECEIVE_DETECT_IN[phy.phy_sop_type] &&
                        (phy.phy_sop_type <= SOP_TYPE_DBG_PP) && !rx_buffer_full;
    assign w_crc_good = (r_crc == CRC_RESIDUE) && (r_count >= CNT_W'(MIN_BYTES));

    crc32_byte u_crc (
        .crc_in  (r_crc),
        .data_in (phy.phy_byte),
        .crc_out (w_crc_upd)
    );

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_type    = r_type;
        w_nxt_count   = r_count;
        w_nxt_crc     = r_crc;
        w_nxt_dly     = r_dly;
        w_nxt_mreq    = 1'b0;
        w_nxt_wr      = r_wr;
        w_nxt_goodcrc = 1'b0;
        w_nxt_ftype   = r_ftype;

        unique case (r_state)
            ST_IDLE: begin
                if (phy.phy_sop_valid) begin
                    w_nxt_type = phy.phy_sop_type;
                    if (w_sop_ok) begin
                        w_nxt_state = ST_RECEIVE;
                        w_nxt_crc   = CRC_INIT;
                        w_nxt_count = '0;
                        w_nxt_dly   = '0;
                    end else begin
                        w_nxt_state = ST_DISCARD;
                    end
                end
            end

            ST_RECEIVE: begin
                // Error beats a coincident EOP; a second SOP mid-packet is treated as corruption.
                if (phy.phy_error || phy.phy_sop_valid) begin
                    w_nxt_state = ST_DISCARD;
                end else if (phy.phy_eop) begin
                    w_nxt_state = ST_CHECK;
                end else if (phy.phy_byte_valid) begin
                    if (r_count >= CNT_W'(MAX_BYTES)) begin
                        w_nxt_state = ST_DISCARD;
                    end else begin
                        w_nxt_crc   = w_crc_upd;
                        w_nxt_count = r_count + CNT_W'(1);
                        w_nxt_dly   = {r_dly[2:0], phy.phy_byte};
                        // The oldest byte in the 4-deep line can no longer be CRC, so commit it.
                        if (r_count >= CNT_W'(CRC_BYTES)) begin
                            w_nxt_mreq    = 1'b1;
                            w_nxt_wr.addr = RX_BASE + OFS_DATA + 8'(r_count) - 8'(CRC_BYTES);
                            w_nxt_wr.data = r_dly[3];
                        end
                    end
                end
            end

            ST_CHECK: begin
                w_nxt_state = w_crc_good ? ST_WR_TYPE : ST_IDLE;
            end

            ST_WR_TYPE: begin
                w_nxt_mreq    = 1'b1;
                w_nxt_wr.addr = RX_BASE + OFS_FRAME_TYPE;
                w_nxt_wr.data = {5'b0, r_type};
                w_nxt_state   = ST_WR_COUNT;
            end

            ST_WR_COUNT: begin
                // Stored length = frame-type byte + header + data, i.e. received bytes minus CRC plus one.
                w_nxt_mreq    = 1'b1;
                w_nxt_wr.addr = RX_BASE + OFS_BYTE_COUNT;
                w_nxt_wr.data = 8'(r_count) - 8'(CRC_BYTES - 1);
                w_nxt_goodcrc = 1'b1;
                w_nxt_ftype   = r_type;
                w_nxt_state   = ST_IDLE;
            end

            ST_DISCARD: begin
                if (phy.phy_eop || phy.phy_error) begin
                    w_nxt_state = ST_IDLE;
                end
            end

            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_type    <= '0;
            r_count   <= '0;
            r_crc     <= CRC_INIT;
            r_dly     <= '0;
            r_mreq    <= 1'b0;
            r_wr      <= '0;
            r_goodcrc <= 1'b0;
            r_ftype   <= '0;
        end else begin
            r_type    <= w_nxt_type;
            r_count   <= w_nxt_count;
            r_crc     <= w_nxt_crc;
            r_dly     <= w_nxt_dly;
            r_mreq    <= w_nxt_mreq;
            r_wr      <= w_nxt_wr;
            r_goodcrc <= w_nxt_goodcrc;
            r_ftype   <= w_nxt_ftype;
        end
    end

`ifdef RX_CRC_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       w_crc_bad;

    assign w_crc_bad = (r_state == ST_CHECK) && !w_crc_good;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_err_cnt <= '0;
        end else if (w_crc_bad && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign crc_err_count = r_err_cnt;
`endif

    assign memory_request = r_mreq;
    assign RNW            = !r_mreq;
    assign DirBus         = r_wr.addr;
    assign DataBusOut     = r_wr.data;
    assign rx_goodcrc     = r_goodcrc;
    assign rx_frame_type  = r_ftype;
    assign idle           = (r_state == ST_IDLE);

endmodule

// File: tb/tb_rx_phy_framer.sv
// Bench for rx_phy_framer: vector table, hand-written corner sequences and random packets scored
// against a packet-level reference model built on the standard reflected CRC-32.
module tb_rx_phy_framer;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] wr_q_t[$];

    typedef struct {
        logic [2:0] t;
        logic [7:0] d;
        bit         f;
        int         plen;
        bit         flip;
        int         egood;
        int         enwr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n, cable_reset, full;
    logic [7:0] det;
    logic       mreq, rnw, gc, idle_o;
    logic [7:0] dir, dout;
    logic [2:0] ftype;
`ifdef RX_CRC_ERR_CNT_EN
    logic [7:0] errcnt;
`endif

    int    checks = 0, failures = 0;
    int    cyc = 0, eop_cyc = 0, rnw_bad = 0;
    int    last_nwr, last_ngc;
    int    m_err = 0;
    logic [2:0] m_ftype = 3'd0;
    bit    use_gaps = 1'b0;
    wr_q_t got_wr;
    int    got_gc[$];

    rx_phy_framer_if phy_if ();

    rx_phy_framer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cable_reset       (cable_reset),
        .phy               (phy_if),
        .RECEIVE_DETECT_IN (det),
        .rx_buffer_full    (full),
        .memory_request    (mreq),
        .RNW               (rnw),
        .DirBus            (dir),
        .DataBusOut        (dout),
        .rx_goodcrc        (gc),
        .rx_frame_type     (ftype),
        .idle              (idle_o)
`ifdef RX_CRC_ERR_CNT_EN
        ,
        .crc_err_count     (errcnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mreq === 1'b1) got_wr.push_back({dir, dout});
        if (gc === 1'b1) got_gc.push_back(cyc);
        if (rnw !== ~mreq) rnw_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Standard reflected CRC-32 register (no final inversion).
    function automatic logic [31:0] crc_reg(input byte_q_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic byte_q_t with_crc(input byte_q_t p, input bit flip);
        logic [31:0] c;
        byte_q_t     r;
        r = p;
        c = ~crc_reg(p);
        for (int i = 0; i < 4; i++) r.push_back(c[8*i +: 8]);
        if (flip) r[r.size()-1] = r[r.size()-1] ^ 8'h01;
        return r;
    endfunction

    // Packet-level expectation: which bytes land where, and whether the frame is accepted.
    function automatic void model(input logic [2:0] t, input logic [7:0] d, input bit f,
                                  input byte_q_t b, input int abort_at,
                                  output wr_q_t e, output bit good, output bit chkd);
        int n_in, n_acc;
        e = {};
        good = 1'b0;
        chkd = 1'b0;
        if (d[t] && t <= 3'd4 && !f) begin
            n_in  = (abort_at >= 0) ? abort_at : b.size();
            n_acc = (n_in > 34) ? 34 : n_in;
            for (int i = 0; i < n_acc - 4; i++) e.push_back({8'h32 + 8'(i), b[i]});
            if (abort_at < 0 && n_in <= 34) begin
                chkd = 1'b1;
                good = (n_in >= 6) && (crc_reg(b) == 32'hDEBB20E3);
                if (good) begin
                    e.push_back({8'h31, 5'b0, t});
                    e.push_back({8'h30, 8'(n_in - 3)});
                end
            end
        end
    endfunction

    // mode 0: normal EOP; 1: error after k bytes then EOP; 2: EOP+error together, then a spare EOP.
    task automatic send(input logic [2:0] t, input byte_q_t b, input int mode, input int k);
        int n;
        n = (mode == 1) ? k : b.size();
        phy_if.phy_sop_type  = t;
        phy_if.phy_sop_valid = 1'b1;
        tick();
        phy_if.phy_sop_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (use_gaps) repeat ($urandom_range(0, 2)) tick();
            phy_if.phy_byte       = b[i];
            phy_if.phy_byte_valid = 1'b1;
            tick();
            phy_if.phy_byte_valid = 1'b0;
        end
        if (mode == 1) begin
            phy_if.phy_error = 1'b1;
            tick();
            phy_if.phy_error = 1'b0;
        end
        eop_cyc          = cyc + 1;
        phy_if.phy_eop   = 1'b1;
        phy_if.phy_error = (mode == 2);
        tick();
        phy_if.phy_eop   = 1'b0;
        phy_if.phy_error = 1'b0;
        if (mode == 2) begin
            phy_if.phy_eop = 1'b1;
            tick();
            phy_if.phy_eop = 1'b0;
        end
        repeat (6) tick();
    endtask

    task automatic run_pkt(input logic [2:0] t, input logic [7:0] d, input bit f,
                           input byte_q_t b, input int mode, input int k);
        wr_q_t e;
        bit    good, chkd;
        int    abort_at;
        abort_at = (mode == 1) ? k : (mode == 2) ? b.size() : -1;
        model(t, d, f, b, abort_at, e, good, chkd);
        det  = d;
        full = f;
        got_wr.delete();
        got_gc.delete();
        send(t, b, mode, k);
        if (good) m_ftype = t;
        if (chkd && !good && m_err != 255) m_err++;
        chk("nwr", got_wr.size(), e.size());
        for (int i = 0; i < e.size() && i < got_wr.size(); i++) chk("wr", got_wr[i], e[i]);
        chk("goodcrc_n", got_gc.size(), good);
        if (good && got_gc.size() > 0) chk("goodcrc_lat", got_gc[0] - eop_cyc, 3);
        chk("frame_type", ftype, m_ftype);
        chk("idle", idle_o, 1'b1);
`ifdef RX_CRC_ERR_CNT_EN
        chk("crc_err_count", errcnt, m_err);
`endif
        last_nwr = got_wr.size();
        last_ngc = got_gc.size();
    endtask

    initial begin
        vec_t       tv[11];
        byte_q_t    pay, pkt;
        logic [2:0] rt;
        logic [7:0] rd;
        bit         rf;
        int         rmode, rk, rplen;

        tv[0]  = '{3'd0, 8'h01, 1'b0, 2,  1'b0, 1, 4};
        tv[1]  = '{3'd0, 8'h01, 1'b0, 2,  1'b1, 0, 2};
        tv[2]  = '{3'd1, 8'h01, 1'b0, 2,  1'b0, 0, 0};
        tv[3]  = '{3'd0, 8'h01, 1'b0, 6,  1'b0, 1, 8};
        tv[4]  = '{3'd0, 8'h01, 1'b1, 6,  1'b0, 0, 0};
        tv[5]  = '{3'd2, 8'h1F, 1'b0, 30, 1'b0, 1, 32};
        tv[6]  = '{3'd4, 8'h10, 1'b0, 4,  1'b0, 1, 6};
        tv[7]  = '{3'd3, 8'h08, 1'b0, 1,  1'b0, 0, 1};
        tv[8]  = '{3'd5, 8'hFF, 1'b0, 2,  1'b0, 0, 0};
        tv[9]  = '{3'd0, 8'h1E, 1'b0, 2,  1'b0, 0, 0};
        tv[10] = '{3'd0, 8'h01, 1'b0, 0,  1'b0, 0, 0};

        reset_n = 1'b0; cable_reset = 1'b0; det = 8'h00; full = 1'b0;
        phy_if.phy_sop_valid = 1'b0; phy_if.phy_sop_type = 3'd0; phy_if.phy_byte_valid = 1'b0;
        phy_if.phy_byte = 8'h00; phy_if.phy_eop = 1'b0; phy_if.phy_error = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_mreq", mreq, 1'b0);
        chk("rst_rnw", rnw, 1'b1);
        chk("rst_dir", dir, 8'h00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_goodcrc", gc, 1'b0);
        chk("rst_ftype", ftype, 3'd0);
        chk("rst_idle", idle_o, 1'b1);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            pay = {};
            if (i < 3) begin
                pay.push_back(8'h41);
                pay.push_back(8'h00);
            end else begin
                for (int j = 0; j < tv[i].plen; j++) pay.push_back(8'($urandom));
            end
            pkt = with_crc(pay, tv[i].flip);
            run_pkt(tv[i].t, tv[i].d, tv[i].f, pkt, 0, 0);
            chk("tv_nwr", last_nwr, tv[i].enwr);
            chk("tv_goodcrc", last_ngc, tv[i].egood);
            if (i == 0) begin
                chk("goodcrc_hdr_wr", {got_wr[0], got_wr[1]}, 32'h32413300);
                chk("goodcrc_cnt_wr", {got_wr[2], got_wr[3]}, 32'h31003003);
            end
        end

        // Error after 3 bytes, then a clean packet.
        pay = {8'h61, 8'h11, 8'hA5, 8'h5A, 8'h3C, 8'hC3};
        pkt = with_crc(pay, 1'b0);
        run_pkt(3'd0, 8'h01, 1'b0, pkt, 1, 3);
        chk("err_goodcrc", last_ngc, 0);
        run_pkt(3'd0, 8'h01, 1'b0, pkt, 0, 0);
        chk("after_err_goodcrc", last_ngc, 1);

        // 35-byte stream overflows at the last byte.
        pay = {};
        for (int j = 0; j < 31; j++) pay.push_back(8'($urandom));
        pkt = with_crc(pay, 1'b0);
        run_pkt(3'd0, 8'h01, 1'b0, pkt, 0, 0);
        chk("ovf_nwr", last_nwr, 30);
        chk("ovf_goodcrc", last_ngc, 0);

        // EOP and error in the same cycle.
        pay = {8'h41, 8'h00, 8'h12, 8'h34};
        pkt = with_crc(pay, 1'b0);
        run_pkt(3'd0, 8'h01, 1'b0, pkt, 2, 0);
        chk("eop_err_goodcrc", last_ngc, 0);

        // reset_n mid-packet, right after a write is on the bus.
        run_pkt(3'd2, 8'h04, 1'b0, pkt, 0, 0);
        det = 8'h01;
        phy_if.phy_sop_type = 3'd0; phy_if.phy_sop_valid = 1'b1; tick(); phy_if.phy_sop_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            phy_if.phy_byte = 8'hE0 + 8'(i); phy_if.phy_byte_valid = 1'b1; tick();
        end
        phy_if.phy_byte_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_ftype = 3'd0;
        m_err = 0;
        @(negedge clk);
        chk("midrst_mreq", mreq, 1'b0);
        chk("midrst_rnw", rnw, 1'b1);
        chk("midrst_dir", dir, 8'h00);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_ftype", ftype, 3'd0);
        chk("midrst_idle", idle_o, 1'b1);
`ifdef RX_CRC_ERR_CNT_EN
        chk("midrst_errcnt", errcnt, 8'h00);
`endif
        tick();
        run_pkt(3'd0, 8'h01, 1'b0, pkt, 0, 0);
        chk("post_rst_goodcrc", last_ngc, 1);

        // cable_reset aborts a packet the same way.
        phy_if.phy_sop_valid = 1'b1; tick(); phy_if.phy_sop_valid = 1'b0;
        phy_if.phy_byte = 8'h77; phy_if.phy_byte_valid = 1'b1; tick(); phy_if.phy_byte_valid = 1'b0;
        cable_reset = 1'b1;
        tick();
        cable_reset = 1'b0;
        m_ftype = 3'd0;
        m_err = 0;
        @(negedge clk);
        chk("cable_rst_idle", idle_o, 1'b1);
        chk("cable_rst_ftype", ftype, 3'd0);
        tick();

        use_gaps = 1'b1;
        for (int r = 0; r < 40; r++) begin
            rt    = 3'($urandom_range(0, 5));
            rd    = 8'($urandom) | (($urandom_range(0, 1) == 1) ? (8'h01 << rt) : 8'h00);
            rf    = ($urandom_range(0, 5) == 0);
            rplen = $urandom_range(0, 31);
            pay   = {};
            for (int j = 0; j < rplen; j++) pay.push_back(8'($urandom));
            pkt   = with_crc(pay, $urandom_range(0, 3) == 0);
            rmode = $urandom_range(0, 5);
            rmode = (rmode < 4) ? 0 : rmode - 3;
            rk    = $urandom_range(0, pkt.size() - 1);
            run_pkt(rt, rd, rf, pkt, rmode, rk);
        end
        use_gaps = 1'b0;

`ifdef RX_CRC_ERR_CNT_EN
        pay = {8'h41, 8'h00};
        pkt = with_crc(pay, 1'b1);
        for (int r = 0; r < 258; r++) run_pkt(3'd0, 8'h01, 1'b0, pkt, 0, 0);
        chk("errcnt_sat", errcnt, 8'hFF);
`endif

        chk("rnw_tracks_mreq", rnw_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
